// File: rtl/mem_stage_bus_unit.sv
// mem_stage_bus_unit
//   Memory-stage access unit. It sits directly behind the EX/MEM register and
//   runs one req/ack transaction per load or store on the data-memory bus. It
//   lane-aligns store data, extracts and extends load data, and freezes the
//   pipeline while a transaction is in flight.
//
// Ports
//   clk, rst_n       rising-edge clock, synchronous active-low reset
//   MemWrite_M       store in M stage
//   MemtoReg_M       load in M stage (a store wins if both are set)
//   ByteControl_M    [1:0] size (00 word, 01 half, 10 byte, 11 word),
//                    [2] 1 = zero-extend load, [3] unused
//   ALU_result_M     byte address
//   WriteData_M      right-justified store data
//   dmem_*           data-memory bus (req/we/addr/be/wdata registered)
//   stall_M          combinational pipeline freeze
//   ReadData_M       extended load result, held until the next capture
//   addr_err_M       combinational misalignment flag
//   bus_err_M        one-cycle pulse when a transaction times out
module mem_stage_bus_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemWrite_M,
  input  logic        MemtoReg_M,
  input  logic [3:0]  ByteControl_M,
  input  logic [31:0] ALU_result_M,
  input  logic [31:0] WriteData_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_M,
  output logic [31:0] ReadData_M,
  output logic        addr_err_M,
  output logic        bus_err_M
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       off_q;
  logic             is_byte_q;
  logic             is_half_q;
  logic             zext_q;
  logic             is_load_q;

  logic        access;
  logic        is_byte;
  logic        is_half;
  logic        misalign;
  logic        start;
  logic [1:0]  off;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        unused_bc3;

  assign unused_bc3 = ByteControl_M[3];

  assign access  = MemWrite_M | MemtoReg_M;
  assign off     = ALU_result_M[1:0];
  assign is_byte = (ByteControl_M[1:0] == 2'b10);
  assign is_half = (ByteControl_M[1:0] == 2'b01);

  // Size 11 falls through to the word rule.
  always_comb begin
    misalign = 1'b0;
    if (is_byte)      misalign = 1'b0;
    else if (is_half) misalign = off[0];
    else              misalign = |off;
  end

  assign addr_err_M = access & misalign;
  assign start      = (state_q == S_IDLE) & access & ~misalign;
  // DONE deliberately drops the stall so the pipeline advances on that edge.
  assign stall_M    = start | (state_q == S_BUSY);

  // Store lane alignment; the same byte enables are used for loads.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = WriteData_M;
    if (is_byte) begin
      be_d    = 4'b0001 << off;
      wdata_d = {4{WriteData_M[7:0]}};
    end else if (is_half) begin
      be_d    = off[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{WriteData_M[15:0]}};
    end
  end

  // Shift the addressed lane down, then extend according to the latched size.
  function automatic logic [31:0] extract(input logic [31:0] rdata,
                                          input logic [1:0]  lane_off,
                                          input logic        b,
                                          input logic        h,
                                          input logic        z);
    logic [31:0] lane;
    lane = rdata >> {lane_off, 3'b000};
    if (b)      return z ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
    else if (h) return z ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
    else        return lane;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      off_q      <= 2'b00;
      is_byte_q  <= 1'b0;
      is_half_q  <= 1'b0;
      zext_q     <= 1'b0;
      is_load_q  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_be    <= 4'h0;
      dmem_wdata <= 32'h0;
      ReadData_M <= 32'h0;
      bus_err_M  <= 1'b0;
    end else begin
      bus_err_M <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_BUSY;
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite_M;
            dmem_addr  <= {ALU_result_M[31:2], 2'b00};
            dmem_be    <= be_d;
            dmem_wdata <= wdata_d;
            off_q      <= off;
            is_byte_q  <= is_byte;
            is_half_q  <= is_half;
            zext_q     <= ByteControl_M[2];
            // A store takes precedence; no read data is captured for it.
            is_load_q  <= MemtoReg_M & ~MemWrite_M;
            cnt_q      <= '0;
          end
        end
        S_BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            state_q  <= S_DONE;
            if (is_load_q) begin
              ReadData_M <= extract(dmem_rdata, off_q, is_byte_q, is_half_q, zext_q);
            end
          end else if (cnt_q == TMO) begin
            dmem_req   <= 1'b0;
            bus_err_M  <= 1'b1;
            ReadData_M <= 32'h0;
            state_q    <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_stage_bus_unit.md
Name: mem_stage_bus_unit

Overview:
- Memory-stage access unit, directly downstream of the EX/MEM pipeline register.
- Consumes ALU_result_M (address), WriteData_M, MemWrite_M, MemtoReg_M and ByteControl_M.
- Runs a req/ack transaction on the data-memory bus, aligns store data, and extracts and extends load data for MEM/WB.
- Drives stall_M to the hazard unit; the EX/MEM register and earlier stages hold while stall_M=1.

Parameters:
- TIMEOUT, 255, maximum BUSY cycles allowed without dmem_ack before the transaction is aborted.
- CNT_W, 8, width of the timeout counter; TIMEOUT must be < 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- MemWrite_M  in  1  store in M stage.
- MemtoReg_M  in  1  load in M stage.
- ByteControl_M  in  4  [1:0] size: 00 word, 01 half, 10 byte, 11 treated as word; [2] 1 = zero-extend load, 0 = sign-extend load; [3] reserved, ignored.
- ALU_result_M  in  32  byte address.
- WriteData_M  in  32  store data, right-justified.
- dmem_req  out  1  bus request, registered.
- dmem_we  out  1  write strobe, valid with req.
- dmem_addr  out  32  word address: {addr[31:2],2'b00}.
- dmem_be  out  4  byte enables, bit i = byte lane i (little-endian).
- dmem_wdata  out  32  lane-aligned store data.
- dmem_rdata  in  32  read data, valid when dmem_ack=1.
- dmem_ack  in  1  single-cycle completion pulse.
- stall_M  out  1  combinational; freeze the pipeline.
- ReadData_M  out  32  extended load result.
- addr_err_M  out  1  combinational misalignment flag.
- bus_err_M  out  1  registered one-cycle timeout pulse.

Behaviour:
- access = MemWrite_M | MemtoReg_M. If both are set, the store takes precedence and no read data is captured.
- Misalignment: word with addr[1:0]≠0, or half with addr[0]≠0, gives addr_err_M=1. No bus request, stall_M=0, instruction passes through. addr_err_M=0 whenever access=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, access & !addr_err_M:
  - stall_M=1.
  - Next edge: go to BUSY; dmem_req<=1; latch dmem_we, dmem_addr, dmem_be, dmem_wdata, byte offset and load size/sign; counter<=0.
- BUSY:
  - stall_M=1; dmem_req and all latched outputs held stable.
  - Edge with dmem_ack=1: capture dmem_rdata, dmem_req<=0, go to DONE.
  - Edge with ack=0 and counter==TIMEOUT: dmem_req<=0, bus_err_M<=1 for one cycle, captured data<=0, go to DONE.
  - Otherwise the counter increments.
- DONE: stall_M=0; ReadData_M valid; pipeline advances on this edge; go to IDLE unconditionally. A new access is not started from DONE.
- Minimum access latency: 3 cycles with ack in the first BUSY cycle. Each cycle of ack delay adds one.
- dmem_ack outside BUSY is ignored.
- Store alignment (off = addr[1:0]):
  - Byte: wdata={4{WD[7:0]}}, be=4'b0001<<off.
  - Half: wdata={2{WD[15:0]}}, be = off[1] ? 4'b1100 : 4'b0011.
  - Word: wdata=WD, be=4'b1111.
- Loads drive dmem_we=0 and dmem_be per size (same rule as stores).
- Load extract: lane = captured_rdata >> (8*off).
  - Byte: lane[7:0], extended to 32 bits.
  - Half: lane[15:0], extended to 32 bits.
  - Word: unchanged.
  - Extension is zero if ByteControl_M[2] else sign. ReadData_M holds its value until the next capture.
- Reset (rst_n=0 at an edge, including mid-transaction):
  - state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0.
  - ReadData_M=0, bus_err_M=0, counter=0.
  - stall_M follows the IDLE rule after reset; a pending ack is discarded.

Test Plan:
- Word store addr 0x100, WD 0xDEADBEEF, ack on first BUSY cycle → req high exactly 1 cycle; be=1111; wdata=0xDEADBEEF; stall_M high for 2 cycles, low in DONE.
- Byte store addr 0x103, WD 0x000000A5 → be=1000, wdata=0xA5A5A5A5, dmem_addr=0x100.
- Signed byte load addr 0x102, rdata 0x00800000, ack after 3 cycles → ReadData_M=0xFFFFFF80; stall_M high 5 cycles. Same with ByteControl_M[2]=1 → 0x00000080.
- Half load addr 0x101 → addr_err_M=1, dmem_req never asserted, stall_M=0.
- No ack, TIMEOUT=4 → req high 5 BUSY cycles, bus_err_M pulses 1 cycle, ReadData_M=0, FSM returns to IDLE.
- rst_n low during BUSY, then ack arrives → req=0 next edge, ack ignored, ReadData_M stays 0.
